gestor_ocupacion: RTL and testbench
===================================

GESTOR_OCUPACION -- requirements
Module: gestor_ocupacion

Interface
REQ-001 Parameter CAPACITY, default 7: maximum number of cars admitted, range 1..7.
REQ-002 Parameter BLINK_DIV, default 6000000: clk cycles per half-period of the full-lot blink.
REQ-003 Parameter ALERT_CYC, default 12000000: clk cycles the rejection alert pattern is held.
REQ-004 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 s  input  1  entry pulse, one clk cycle wide, from the sensor FSM.
REQ-007 r  input  1  exit pulse, one clk cycle wide, from the sensor FSM.
REQ-008 cuenta  output  3  registered occupancy count.
REQ-009 lleno  output  1  high when cuenta == CAPACITY.
REQ-010 vacio  output  1  high when cuenta == 0.
REQ-011 rechazo  output  1  one-cycle pulse when an event is rejected.
REQ-012 leds  output  4  driven as {LED3, LED2, LED1, LED0}.

Function
REQ-013 When s=1, r=0 and cuenta<CAPACITY, cuenta SHALL increment on the next edge.
REQ-014 When s=1, r=0 and cuenta==CAPACITY, cuenta SHALL hold and rechazo SHALL pulse on the next cycle.
REQ-015 When r=1, s=0 and cuenta>0, cuenta SHALL decrement on the next edge.
REQ-016 When r=1, s=0 and cuenta==0, cuenta SHALL hold and rechazo SHALL pulse on the next cycle.
REQ-017 When s=1 and r=1 together, cuenta SHALL hold with no rechazo, including at full or empty.
REQ-018 cuenta SHALL never wrap: it stays within 0..CAPACITY under all inputs.
REQ-019 lleno and vacio SHALL be decoded combinationally from the cuenta register, adding no extra latency.
REQ-020 The display FSM SHALL have three states: NORMAL, LLENO, ALERTA.
REQ-021 NORMAL: leds = {0, cuenta}; go to LLENO when lleno=1.
REQ-022 LLENO: leds = {fase, cuenta}; go to NORMAL when lleno=0.
REQ-023 Any rechazo, from any state, SHALL enter ALERTA and load the alert timer with ALERT_CYC-1.
REQ-024 ALERTA: leds = 4'b1111; a new rechazo reloads the timer; at timer 0 go to LLENO if lleno, else NORMAL.
REQ-025 Blink divider: counts 0..BLINK_DIV-1 and toggles fase at wrap; it runs only in LLENO.
REQ-026 Outside LLENO the blink divider SHALL be cleared with fase=1, so LED3 is lit on the first LLENO cycle.
REQ-027 Counting SHALL continue normally during ALERTA.

Reset
REQ-028 rst SHALL asynchronously force: cuenta=0, state=NORMAL, alert timer=0, divider=0, fase=1, rechazo=0.
REQ-029 Resulting outputs: leds=0000, vacio=1, lleno=0.
REQ-030 A rst asserted mid-alert or mid-blink SHALL abandon that activity with no residual pulse after release.

Configuration
REQ-031 Macro FULL_BLINK_EN controls the LED3 blink in LLENO.
REQ-032 Defined: LLENO blinks LED3 as per REQ-025/026.
REQ-033 Undefined: the blink divider is not instantiated and LED3 is steady 1 in LLENO; all other behaviour is identical.

Structure
REQ-034 Shared package tfi_pkg SHALL hold the display-state enum (NORMAL, LLENO, ALERTA) and the default CAPACITY, BLINK_DIV and ALERT_CYC constants.
REQ-035 Sub-module divisor_parpadeo (inputs clk, rst, en; output fase) SHALL implement the blink divider.

Verification (CAPACITY=3, BLINK_DIV=4, ALERT_CYC=5)
REQ-036 Reset: rst pulse -> cuenta=0, leds=0000, vacio=1, rechazo=0.
REQ-037 Fill: 3 s pulses -> cuenta=3, lleno=1, leds[2:0]=011.
REQ-037a Fill, blink: LED3 = 1,1,1,1,0,0,0,0,1... per cycle after entering LLENO.
REQ-038 Overflow: 4th s pulse at cuenta=3 -> cuenta stays 3 and rechazo=1 for exactly 1 cycle.
REQ-038a Overflow, alert: leds=1111 for 5 cycles, then return to LLENO.
REQ-039 Simultaneous: s=r=1 at cuenta=0 and at cuenta=3 -> cuenta unchanged, no rechazo.
REQ-040 Underflow: r pulse at cuenta=0 -> rechazo pulse, ALERTA, then NORMAL with leds=0000.
REQ-040a Underflow, retrigger: second r 2 cycles into ALERTA -> alert lasts 5 cycles from the second pulse.
REQ-041 Reset mid-alert: rst during ALERTA with cuenta=2 -> leds=0000 immediately and cuenta=0.
REQ-041a Reset mid-alert, release: no rechazo pulse after rst is released.

Source files
------------

// File: rtl/tfi_pkg.sv
// Shared types and default sizing for the parking occupancy manager.
package tfi_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        LLENO  = 2'd1,
        ALERTA = 2'd2
    } estado_t;

    localparam int CAPACITY_DEF  = 7;
    localparam int BLINK_DIV_DEF = 6000000;
    localparam int ALERT_CYC_DEF = 12000000;

endpackage

// File: rtl/divisor_parpadeo.sv
// Blink divider: toggles fase every BLINK_DIV cycles while en is high;
// held cleared with fase=1 otherwise so a fresh blink starts lit.
module divisor_parpadeo
    import tfi_pkg::*;
#(
    parameter int BLINK_DIV = BLINK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic fase
);

    localparam int CW = $clog2(BLINK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          fase_q, fase_d;

    always_comb begin
        cnt_d  = cnt_q;
        fase_d = fase_q;
        if (!en) begin
            cnt_d  = '0;
            fase_d = 1'b1;
        end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
            cnt_d  = '0;
            fase_d = ~fase_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            fase_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            fase_q <= fase_d;
        end
    end

    assign fase = fase_q;

endmodule

// File: rtl/gestor_ocupacion.sv
// Parking occupancy counter with full/empty flags, rejection pulse and LED display FSM.
// Define FULL_BLINK_EN to blink LED3 while the lot is full; otherwise LED3 is steady.
module gestor_ocupacion
    import tfi_pkg::*;
#(
    parameter int CAPACITY  = CAPACITY_DEF,
    parameter int BLINK_DIV = BLINK_DIV_DEF,
    parameter int ALERT_CYC = ALERT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s,
    input  logic       r,
    output logic [2:0] cuenta,
    output logic       lleno,
    output logic       vacio,
    output logic       rechazo,
    output logic [3:0] leds
);

    localparam int             TW      = $clog2(ALERT_CYC + 1);
    localparam logic [2:0]     CAP     = 3'(CAPACITY);
    localparam logic [TW-1:0]  T_CARGA = TW'(ALERT_CYC - 1);

    logic [2:0]    cuenta_q, cuenta_d;
    logic          rechazo_q, rechazo_d;
    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          fase;
    logic          div_en;

    assign cuenta  = cuenta_q;
    assign lleno   = (cuenta_q == CAP);
    assign vacio   = (cuenta_q == 3'd0);
    assign rechazo = rechazo_q;
    assign div_en  = (estado_q == LLENO);

    // Simultaneous s and r cancel out and are never a rejection.
    always_comb begin
        cuenta_d  = cuenta_q;
        rechazo_d = 1'b0;
        if (s && !r) begin
            if (cuenta_q == CAP) rechazo_d = 1'b1;
            else                 cuenta_d  = cuenta_q + 3'd1;
        end else if (r && !s) begin
            if (cuenta_q == 3'd0) rechazo_d = 1'b1;
            else                  cuenta_d  = cuenta_q - 3'd1;
        end
    end

    // The alert starts on the same edge that raises rechazo, so the pulse
    // and the first 1111 cycle coincide.
    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;
        if (rechazo_d) begin
            estado_d = ALERTA;
            timer_d  = T_CARGA;
        end else begin
            case (estado_q)
                NORMAL: if (lleno)  estado_d = LLENO;
                LLENO:  if (!lleno) estado_d = NORMAL;
                ALERTA: begin
                    if (timer_q == '0) estado_d = lleno ? LLENO : NORMAL;
                    else               timer_d  = timer_q - TW'(1);
                end
                default: estado_d = NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta_q  <= 3'd0;
            rechazo_q <= 1'b0;
            estado_q  <= NORMAL;
            timer_q   <= '0;
        end else begin
            cuenta_q  <= cuenta_d;
            rechazo_q <= rechazo_d;
            estado_q  <= estado_d;
            timer_q   <= timer_d;
        end
    end

    // leds depend only on registers, so they carry no combinational path from s/r.
    always_comb begin
        case (estado_q)
            NORMAL:  leds = {1'b0, cuenta_q};
            LLENO:   leds = {fase, cuenta_q};
            ALERTA:  leds = 4'b1111;
            default: leds = 4'b0000;
        endcase
    end

`ifdef FULL_BLINK_EN
    divisor_parpadeo #(
        .BLINK_DIV(BLINK_DIV)
    ) u_divisor (
        .clk (clk),
        .rst (rst),
        .en  (div_en),
        .fase(fase)
    );
`else
    // No divider: LED3 is simply lit for the whole full-lot period.
    localparam logic FASE_FIJA = (BLINK_DIV > 0);
    assign fase = FASE_FIJA | div_en;
`endif

endmodule

// File: tb/tb_gestor_ocupacion.sv
// Self-checking bench for gestor_ocupacion with CAPACITY=3, BLINK_DIV=4, ALERT_CYC=5.
module tb_gestor_ocupacion;

    localparam int CAP   = 3;
    localparam int BLINK = 4;
    localparam int ALERT = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       s, r;
    logic [2:0] cuenta;
    logic       lleno, vacio, rechazo;
    logic [3:0] leds;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    gestor_ocupacion #(
        .CAPACITY (CAP),
        .BLINK_DIV(BLINK),
        .ALERT_CYC(ALERT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s      (s),
        .r      (r),
        .cuenta (cuenta),
        .lleno  (lleno),
        .vacio  (vacio),
        .rechazo(rechazo),
        .leds   (leds)
    );

    always #5 clk = ~clk;

    // Model: car count, cycles of 1111 still to show, and cycles spent in the
    // full-lot display (-1 when not in it).
    typedef struct {
        int cnt;
        int alert;
        int age;
        bit rech;
    } mdl_t;

    mdl_t m = '{0, 0, -1, 1'b0};

    function automatic mdl_t paso(mdl_t o, logic si, logic ri);
        mdl_t n;
        bit   rej;
        n   = o;
        rej = (si && !ri && o.cnt == CAP) || (ri && !si && o.cnt == 0);
        if (si && !ri && !rej) n.cnt = o.cnt + 1;
        if (ri && !si && !rej) n.cnt = o.cnt - 1;
        n.rech = rej;
        if (rej) begin
            n.alert = ALERT;
            n.age   = -1;
        end else if (o.alert > 0) begin
            n.alert = o.alert - 1;
            if (n.alert == 0) n.age = (o.cnt == CAP) ? 0 : -1;
        end else if (o.age >= 0) begin
            n.age = (o.cnt == CAP) ? o.age + 1 : -1;
        end else if (o.cnt == CAP) begin
            n.age = 0;
        end
        return n;
    endfunction

    function automatic logic [9:0] esperado(mdl_t x);
        logic [2:0] c;
        logic [3:0] l;
        logic       f;
        c = 3'(x.cnt);
`ifdef FULL_BLINK_EN
        f = ((x.age / BLINK) % 2) == 0;
`else
        f = 1'b1;
`endif
        if (x.alert > 0)     l = 4'hF;
        else if (x.age >= 0) l = {f, c};
        else                 l = {1'b0, c};
        return {c, x.cnt == CAP, x.cnt == 0, x.rech, l};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{0, 0, -1, 1'b0};
        else     m <= paso(m, s, r);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (chk_en)
            chk("ciclo", {22'd0, cuenta, lleno, vacio, rechazo, leds}, {22'd0, esperado(m)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic si, input logic ri);
        s = si;
        r = ri;
        tick();
        s = 1'b0;
        r = 1'b0;
    endtask

    logic [8:0] seq;
    logic [8:0] seq_exp;
    int         nf;
    bit         rech_visto;

    initial begin
        rst = 1'b0;
        s   = 1'b0;
        r   = 1'b0;
        #2 rst = 1'b1;
        repeat (2) tick();
        chk_en = 1'b1;
        rst    = 1'b0;
        #1;
        chk("rst_cuenta",  32'(cuenta),  32'd0);
        chk("rst_leds",    32'(leds),    32'd0);
        chk("rst_vacio",   32'(vacio),   32'd1);
        chk("rst_lleno",   32'(lleno),   32'd0);
        chk("rst_rechazo", 32'(rechazo), 32'd0);

        // Fill to capacity.
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        chk("fill_cuenta", 32'(cuenta), 32'd3);
        chk("fill_lleno",  32'(lleno),  32'd1);
        chk("fill_vacio",  32'(vacio),  32'd0);
        chk("fill_leds",   32'(leds),   32'h3);

        // LED3 per cycle after entering the full display.
        seq = '0;
        for (int k = 0; k < 9; k++) begin
            tick();
            seq = {seq[7:0], leds[3]};
        end
`ifdef FULL_BLINK_EN
        seq_exp = 9'b111100001;
`else
        seq_exp = 9'b111111111;
`endif
        chk("blink_seq", 32'(seq), 32'(seq_exp));

        // Overflow.
        pulse(1'b1, 1'b0);
        chk("ovf_rechazo", 32'(rechazo), 32'd1);
        chk("ovf_cuenta",  32'(cuenta),  32'd3);
        chk("ovf_leds",    32'(leds),    32'hF);
        nf = 1;
        tick();
        chk("ovf_rechazo_1c", 32'(rechazo), 32'd0);
        while (leds == 4'hF && nf < 20) begin
            nf++;
            tick();
        end
        chk("ovf_alert_len", 32'(nf),   32'd5);
        chk("ovf_vuelta",    32'(leds), 32'hB);

        // Simultaneous at full.
        pulse(1'b1, 1'b1);
        chk("sim3_cuenta",  32'(cuenta),  32'd3);
        chk("sim3_rechazo", 32'(rechazo), 32'd0);
        chk("sim3_leds",    32'(leds),    32'hB);

        // Empty the lot, then simultaneous at empty.
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1);
        repeat (2) tick();
        pulse(1'b1, 1'b1);
        chk("sim0_cuenta",  32'(cuenta),  32'd0);
        chk("sim0_rechazo", 32'(rechazo), 32'd0);
        chk("sim0_leds",    32'(leds),    32'h0);

        // Underflow with retrigger two cycles into the alert.
        pulse(1'b0, 1'b1);
        chk("udf_rechazo", 32'(rechazo), 32'd1);
        chk("udf_leds",    32'(leds),    32'hF);
        chk("udf_cuenta",  32'(cuenta),  32'd0);
        tick();
        pulse(1'b0, 1'b1);
        chk("retrig_rechazo", 32'(rechazo), 32'd1);
        nf = 1;
        tick();
        while (leds == 4'hF && nf < 20) begin
            nf++;
            tick();
        end
        chk("retrig_alert_len", 32'(nf),   32'd5);
        chk("retrig_normal",    32'(leds), 32'h0);

        // Reset during an alert with two cars inside.
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        chk("mid_leds",   32'(leds),   32'hF);
        chk("mid_cuenta", 32'(cuenta), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_leds",   32'(leds),   32'h0);
        chk("mid_rst_cuenta", 32'(cuenta), 32'd0);
        tick();
        rst = 1'b0;
        rech_visto = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rechazo || leds != 4'h0) rech_visto = 1'b1;
        end
        chk("mid_release_quiet", 32'(rech_visto), 32'd0);

        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
